hist_equalize: RTL

HIST_EQUALIZE -- requirements
Module: hist_equalize

---
 rtl/hist_equalize_pkg.sv | 28 ++
 rtl/hist_div.sv | 74 +++++++
 rtl/hist_equalize.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/hist_equalize_pkg.sv
// hist_pkg: shared constants, FSM state encoding and the saturating CDF add
// used by the histogram-equalization LUT builder.
package hist_pkg;

  localparam int HIST_W           = 19;      // histogram bin / CDF width
  localparam int BIN_N            = 256;     // number of gray levels
  localparam int LUT_W            = 8;       // LUT entry width
  localparam int TOTAL_PIXELS_DEF = 307200;  // 640x480

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    ACC,
    DIV,
    WRITE,
    DONE
  } state_e;

  // CDF accumulation clamps at the top of the 19-bit range instead of wrapping.
  function automatic logic [HIST_W-1:0] sat_add(input logic [HIST_W-1:0] a,
                                                input logic [HIST_W-1:0] b);
    logic [HIST_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[HIST_W] ? '1 : s[HIST_W-1:0];
  endfunction

endpackage

// File: rtl/hist_div.sv
// hist_div: restoring unsigned divider, one quotient bit per cycle.
// The first bit is resolved in the start cycle, so a DIV_W-bit quotient takes
// DIV_W cycles and done pulses for one cycle right after the last bit.
// Ports:
//   cam_clk, rst_n  clock / async active-low reset
//   start           one-cycle pulse, samples dividend and divisor
//   dividend        DIV_W-bit numerator
//   divisor         DSR_W-bit denominator
//   done            one-cycle pulse, quotient valid while done is high
//   quotient        DIV_W-bit result (holds until next start)
module hist_div #(
  parameter int DIV_W = 27,
  parameter int DSR_W = 19
) (
  input  logic             cam_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DSR_W-1:0] divisor,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DIV_W + 1);

  logic [DSR_W-1:0] rem_q, dsr_q, r_in, d_in, r_nxt;
  logic [DIV_W-1:0] quo_q, q_in;
  logic [DSR_W:0]   trial;
  logic             ge, run_q, done_q;
  logic [CNT_W-1:0] cnt_q;

  // One restoring step; on start it operates on the fresh operands directly.
  always_comb begin
    r_in  = start ? '0       : rem_q;
    q_in  = start ? dividend : quo_q;
    d_in  = start ? divisor  : dsr_q;
    trial = {r_in, q_in[DIV_W-1]};
    ge    = (trial >= {1'b0, d_in});
    // remainder stays below divisor, so it always fits DSR_W bits
    r_nxt = ge ? DSR_W'(trial - {1'b0, d_in}) : trial[DSR_W-1:0];
  end

  always_ff @(posedge cam_clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dsr_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q <= r_nxt;
        quo_q <= {q_in[DIV_W-2:0], ge};
        dsr_q <= d_in;
        cnt_q <= CNT_W'(DIV_W - 1);
        run_q <= 1'b1;
      end else if (run_q) begin
        rem_q <= r_nxt;
        quo_q <= {q_in[DIV_W-2:0], ge};
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/hist_equalize.sv
// hist_equalize: histogram-equalization LUT builder and 1-cycle pixel mapper.
// A frame's histogram is read bin by bin, accumulated into a CDF, scaled to
// 0..255 by CDF*255/TOTAL_PIXELS and written into a shadow LUT bank. The
// shadow becomes active on the next vsync rising edge after the build ends.
// Ports:
//   cam_clk, rst_n                 clock / async active-low reset
//   cam_vsync/href/valid, cam_gray camera input stream
//   build_start                    histogram of previous frame ready
//   hist_rd_en/addr, hist_rd_data  bin read port (1-cycle latency)
//   post_frame_vsync/href/clken    input sync/valid delayed 1 cycle
//   post_img_Y                     equalized pixel (1-cycle latency)
//   busy                           LUT build in progress
//   lut_ready                      pulse: new LUT just became active
module hist_equalize
  import hist_pkg::*;
#(
  parameter int TOTAL_PIXELS = TOTAL_PIXELS_DEF,
  parameter int DIV_W        = 27
) (
  input  logic              cam_clk,
  input  logic              rst_n,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              cam_valid,
  input  logic [LUT_W-1:0]  cam_gray,
  input  logic              build_start,
  output logic              hist_rd_en,
  output logic [7:0]        hist_rd_addr,
  input  logic [HIST_W-1:0] hist_rd_data,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [LUT_W-1:0]  post_img_Y,
  output logic              busy,
  output logic              lut_ready
);

  state_e state, state_nxt;

  logic [HIST_W-1:0]                   cdf, cdf_sum;
  logic [7:0]                          addr;
  logic                                bank_sel, shadow_sel, swap_pending, lut_ready_q;
  logic [1:0][BIN_N-1:0][LUT_W-1:0]    lut;
  logic                                vsync_d, href_d, clken_d, vs_rise;
  logic [LUT_W-1:0]                    y_q;
  logic                                div_start, div_done;
  logic [DIV_W-1:0]                    dividend, quotient;
  logic [LUT_W-1:0]                    q_sat;

  assign shadow_sel = ~bank_sel;
  assign vs_rise    = cam_vsync & ~vsync_d;
  assign cdf_sum    = sat_add(cdf, hist_rd_data);
  assign dividend   = DIV_W'(cdf_sum) * DIV_W'(255);
  assign div_start  = (state == ACC);
  assign q_sat      = (quotient > DIV_W'(255)) ? '1 : quotient[LUT_W-1:0];

  hist_div #(
    .DIV_W (DIV_W),
    .DSR_W (HIST_W)
  ) u_div (
    .cam_clk  (cam_clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (HIST_W'(TOTAL_PIXELS)),
    .done     (div_done),
    .quotient (quotient)
  );

  // ---------------- build FSM ----------------
  always_ff @(posedge cam_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    hist_rd_en = 1'b0;
    unique case (state)
      IDLE:  if (build_start) state_nxt = READ;
      READ:  begin
        hist_rd_en = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT:  state_nxt = ACC;
      ACC:   state_nxt = DIV;
      DIV:   if (div_done) state_nxt = WRITE;
      WRITE: state_nxt = (addr == 8'(BIN_N - 1)) ? DONE : READ;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign hist_rd_addr = addr;

  // ---------------- build datapath, banks and swap ----------------
  always_ff @(posedge cam_clk or negedge rst_n) begin
    if (!rst_n) begin
      cdf          <= '0;
      addr         <= '0;
      bank_sel     <= 1'b0;
      swap_pending <= 1'b0;
      lut_ready_q  <= 1'b0;
      for (int i = 0; i < BIN_N; i++) begin
        lut[0][i] <= LUT_W'(i);
        lut[1][i] <= LUT_W'(i);
      end
    end else begin
      lut_ready_q <= 1'b0;
      // swap_pending is sampled before DONE can set it, so a build that ends
      // on the same cycle as a vsync rise waits for the following rise
      if (vs_rise && swap_pending) begin
        bank_sel     <= ~bank_sel;
        swap_pending <= 1'b0;
        lut_ready_q  <= 1'b1;
      end
      case (state)
        IDLE: if (build_start) begin
          cdf  <= '0;
          addr <= '0;
        end
        ACC:   cdf <= cdf_sum;
        WRITE: begin
          lut[shadow_sel][addr] <= q_sat;
          if (addr != 8'(BIN_N - 1)) addr <= addr + 8'd1;
        end
        DONE:  swap_pending <= 1'b1;
        default: ;
      endcase
    end
  end

  assign lut_ready = lut_ready_q;

  // ---------------- pixel path, 1-cycle latency ----------------
  always_ff @(posedge cam_clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
      clken_d <= 1'b0;
      y_q     <= '0;
    end else begin
      vsync_d <= cam_vsync;
      href_d  <= cam_href;
      clken_d <= cam_valid;
      y_q     <= cam_valid ? lut[bank_sel][cam_gray] : '0;
    end
  end

  assign post_frame_vsync = vsync_d;
  assign post_frame_href  = href_d;
  assign post_frame_clken = clken_d;
  assign post_img_Y       = y_q;

endmodule
